// File: rtl/dcache_pkg.sv
// Shared sizing helper and per-line flag layout for the set-associative dcache array.
// Pure declarations: no latency and no backpressure.
package dcache_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Tag is held in its own array so that TAG_W can stay a module parameter.
  typedef struct packed {
    logic valid;
    logic dirty;
  } line_flags_t;

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age update for one set: touched way goes to age 0 and younger ways age by one.
// Combinational with zero latency; there is no backpressure.
module dcache_lru #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1
) (
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] age_i,
  input  logic [WAY_W-1:0]               way_i,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] age_o,
  output logic [WAY_W-1:0]               lru_way_o
);

  logic [WAY_W-1:0] old_age;

  always_comb begin
    old_age   = age_i[way_i];
    age_o     = age_i;
    lru_way_o = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == way_i) begin
        age_o[w] = '0;
      end else if (age_i[w] < old_age) begin
        age_o[w] = age_i[w] + WAY_W'(1);
      end
      if (age_i[w] == WAY_W'(NUM_WAYS - 1)) begin
        lru_way_o = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way dcache tag/data array with true-LRU victim selection; zero-latency lookup, state on clk_i.
// No backpressure: one access is accepted every cycle. DCACHE_PERF_CNT_EN adds read hit/miss counters.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int TAG_W    = 23,
  parameter int LINE_W   = 256,
`ifdef DCACHE_PERF_CNT_EN
  parameter int CNT_W    = 32,
`endif
  localparam int IDX_W   = clog2(NUM_SETS),
  localparam int WAY_W   = clog2(NUM_WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o,
  output logic [LINE_W-1:0] data_o,
  output logic              victim_valid_o,
  output logic              victim_dirty_o,
  output logic [TAG_W-1:0]  victim_tag_o,
  output logic [LINE_W-1:0] victim_data_o
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
`endif
);

  logic [TAG_W-1:0]              tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]             data_q  [NUM_SETS][NUM_WAYS];
  line_flags_t                   flags_q [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0][WAY_W-1:0] age_q  [NUM_SETS];

  logic                          hit_any;
  logic [WAY_W-1:0]              hit_way;
  logic                          inv_any;
  logic [WAY_W-1:0]              inv_way;
  logic [WAY_W-1:0]              lru_way;
  logic [WAY_W-1:0]              victim_way;
  logic [WAY_W-1:0]              acc_way;
  logic [NUM_WAYS-1:0][WAY_W-1:0] age_nxt;
  logic                          touch;

  // Descending scan so the lowest matching (or invalid) way is the one that sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (flags_q[addr_i][w].valid && (tag_q[addr_i][w] == tag_i)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!flags_q[addr_i][w].valid) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim_way = inv_any ? inv_way : lru_way;
  assign acc_way    = hit_any ? hit_way : victim_way;
  assign touch      = enable_i && (hit_any || write_i);

  dcache_lru #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_lru (
    .age_i     (age_q[addr_i]),
    .way_i     (acc_way),
    .age_o     (age_nxt),
    .lru_way_o (lru_way)
  );

  assign hit_o          = enable_i && hit_any;
  assign way_o          = hit_o ? hit_way : '0;
  assign data_o         = hit_o ? data_q[addr_i][hit_way] : '0;
  assign victim_valid_o = flags_q[addr_i][victim_way].valid;
  assign victim_dirty_o = flags_q[addr_i][victim_way].dirty;
  assign victim_tag_o   = tag_q[addr_i][victim_way];
  assign victim_data_o  = data_q[addr_i][victim_way];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          flags_q[s][w] <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else if (enable_i) begin
      if (write_i && hit_any) begin
        flags_q[addr_i][hit_way].dirty <= dirty_i;
      end else if (write_i) begin
        flags_q[addr_i][victim_way] <= '{valid: 1'b1, dirty: dirty_i};
      end
      if (touch) begin
        age_q[addr_i] <= age_nxt;
      end
    end
  end

  // Line payload is never cleared; reset only blocks a coincident write.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enable_i && write_i) begin
      if (hit_any) begin
        data_q[addr_i][hit_way] <= data_i;
      end else begin
        data_q[addr_i][victim_way] <= data_i;
        tag_q[addr_i][victim_way]  <= tag_i;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (enable_i && !write_i) begin
      if (hit_any) begin
        if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_W'(1);
      end else begin
        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway (16 sets, 2 ways); perf counters exercised when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_sram_nway;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         write;
  logic [3:0]   addr;
  logic [22:0]  tag;
  logic [255:0] wdata;
  logic         dirty;
  logic         hit;
  logic [0:0]   way;
  logic [255:0] rdata;
  logic         vic_valid;
  logic         vic_dirty;
  logic [22:0]  vic_tag;
  logic [255:0] vic_data;
`ifdef DCACHE_PERF_CNT_EN
  logic [3:0]   hit_cnt;
  logic [3:0]   miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] DA = {8{32'hAAAA_0001}};
  localparam logic [255:0] DB = {8{32'hBBBB_0002}};
  localparam logic [255:0] DC = {8{32'hCCCC_0003}};
  localparam logic [255:0] DD = {8{32'hDDDD_0004}};

  dcache_sram_nway #(
    .NUM_SETS (16),
    .NUM_WAYS (2),
    .TAG_W    (23),
    .LINE_W   (256)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .CNT_W    (4)
`endif
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .write_i        (write),
    .addr_i         (addr),
    .tag_i          (tag),
    .data_i         (wdata),
    .dirty_i        (dirty),
    .hit_o          (hit),
    .way_o          (way),
    .data_o         (rdata),
    .victim_valid_o (vic_valid),
    .victim_dirty_o (vic_dirty),
    .victim_tag_o   (vic_tag),
    .victim_data_o  (vic_data)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o      (hit_cnt),
    .miss_cnt_o     (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic en, input logic wr, input logic [3:0] a,
                       input logic [22:0] t, input logic [255:0] d, input logic dy);
    enable = en;
    write  = wr;
    addr   = a;
    tag    = t;
    wdata  = d;
    dirty  = dy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 23'd0, '0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'd3, 23'h1, '0, 1'b0);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b want=0", hit); end
    total++; if (way !== 1'b0) begin bad++; $display("FAIL reset_way got=%0d want=0", way); end
    total++; if (rdata !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", rdata); end
    total++; if (vic_valid !== 1'b0) begin bad++; $display("FAIL reset_vic_valid got=%0b want=0", vic_valid); end
    total++; if (vic_dirty !== 1'b0) begin bad++; $display("FAIL reset_vic_dirty got=%0b want=0", vic_dirty); end
  endtask

  task automatic test_refill();
    drive(1'b1, 1'b1, 4'd3, 23'h1, DA, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'd3, 23'h2, DB, 1'b0);
    total++; if (vic_valid !== 1'b0) begin bad++; $display("FAIL refill_way1_free got=%0b want=0", vic_valid); end
    tick();
    drive(1'b1, 1'b0, 4'd3, 23'h1, '0, 1'b0);
    total++; if (hit !== 1'b1 || way !== 1'b0) begin bad++; $display("FAIL refill_hit_a got=%0b/%0d want=1/0", hit, way); end
    total++; if (rdata !== DA) begin bad++; $display("FAIL refill_data_a got=%h want=%h", rdata, DA); end
    drive(1'b1, 1'b0, 4'd3, 23'h2, '0, 1'b0);
    total++; if (hit !== 1'b1 || way !== 1'b1) begin bad++; $display("FAIL refill_hit_b got=%0b/%0d want=1/1", hit, way); end
    total++; if (rdata !== DB) begin bad++; $display("FAIL refill_data_b got=%h want=%h", rdata, DB); end
    drive(1'b0, 1'b0, 4'd3, 23'h2, '0, 1'b0);
    total++; if (hit !== 1'b0 || way !== 1'b0 || rdata !== '0) begin bad++; $display("FAIL enable_gate got=%0b/%0d want=0/0", hit, way); end
    drive(1'b1, 1'b0, 4'd5, 23'h1, '0, 1'b0);
    total++; if (hit !== 1'b0 || vic_valid !== 1'b0) begin bad++; $display("FAIL other_set got=%0b/%0b want=0/0", hit, vic_valid); end
  endtask

  task automatic test_replace();
    drive(1'b1, 1'b0, 4'd3, 23'h1, '0, 1'b0);
    tick();
    total++; if (vic_valid !== 1'b1 || vic_tag !== 23'h2) begin bad++; $display("FAIL lru_victim got=%0b/%h want=1/2", vic_valid, vic_tag); end
    drive(1'b1, 1'b1, 4'd3, 23'h3, DC, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd3, 23'h3, '0, 1'b0);
    total++; if (hit !== 1'b1 || way !== 1'b1 || rdata !== DC) begin bad++; $display("FAIL replace_new got=%0b/%0d want=1/1", hit, way); end
    drive(1'b1, 1'b0, 4'd3, 23'h2, '0, 1'b0);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL replace_evicted got=%0b want=0", hit); end
    drive(1'b1, 1'b0, 4'd3, 23'h1, '0, 1'b0);
    total++; if (hit !== 1'b1 || way !== 1'b0 || rdata !== DA) begin bad++; $display("FAIL replace_kept got=%0b/%0d want=1/0", hit, way); end
  endtask

  task automatic test_write_hit();
    drive(1'b1, 1'b1, 4'd3, 23'h1, DD, 1'b1);
    total++; if (hit !== 1'b1 || way !== 1'b0 || rdata !== DA) begin bad++; $display("FAIL wr_hit_pre got=%0b/%0d want=1/0", hit, way); end
    tick();
    drive(1'b1, 1'b0, 4'd3, 23'h3, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd3, 23'h0, '0, 1'b0);
    total++; if (vic_valid !== 1'b1 || vic_dirty !== 1'b1) begin bad++; $display("FAIL wr_vic_flags got=%0b/%0b want=1/1", vic_valid, vic_dirty); end
    total++; if (vic_tag !== 23'h1 || vic_data !== DD) begin bad++; $display("FAIL wr_vic_line got=%h want=1", vic_tag); end
    drive(1'b1, 1'b0, 4'd3, 23'h9, '0, 1'b0);
    tick();
    total++; if (vic_tag !== 23'h1) begin bad++; $display("FAIL read_miss_no_touch got=%h want=1", vic_tag); end
    drive(1'b1, 1'b0, 4'd3, 23'h1, '0, 1'b0);
    total++; if (hit !== 1'b1 || rdata !== DD) begin bad++; $display("FAIL wr_data got=%h want=%h", rdata, DD); end
  endtask

  task automatic test_reset_with_write();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 4'd3, 23'h7, DB, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'd3, 23'h7, '0, 1'b0);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL rst_blocks_write got=%0b want=0", hit); end
    drive(1'b1, 1'b0, 4'd3, 23'h1, '0, 1'b0);
    total++; if (hit !== 1'b0 || vic_valid !== 1'b0 || vic_dirty !== 1'b0) begin bad++; $display("FAIL rst_clears_set got=%0b/%0b/%0b want=0/0/0", hit, vic_valid, vic_dirty); end
    drive(1'b1, 1'b1, 4'd3, 23'h11, DA, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'd3, 23'h12, DB, 1'b0);
    total++; if (vic_valid !== 1'b0) begin bad++; $display("FAIL rst_fill_way1_free got=%0b want=0", vic_valid); end
    tick();
    drive(1'b0, 1'b0, 4'd3, 23'h0, '0, 1'b0);
    total++; if (vic_valid !== 1'b1 || vic_tag !== 23'h11) begin bad++; $display("FAIL rst_lru_after got=%0b/%h want=1/11", vic_valid, vic_tag); end
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 23'h0, '0, 1'b0);
    tick();
    rst_n = 1'b1;
    total++; if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d want=0/0", hit_cnt, miss_cnt); end
    drive(1'b1, 1'b1, 4'd0, 23'h5, DA, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 4'd0, 23'h5, '0, 1'b0); tick(); end
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 4'd0, 23'h6, '0, 1'b0); tick(); end
    drive(1'b1, 1'b1, 4'd0, 23'h5, DB, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 23'h5, '0, 1'b0);
    tick();
    total++; if (hit_cnt !== 4'd3 || miss_cnt !== 4'd2) begin bad++; $display("FAIL perf_count got=%0d/%0d want=3/2", hit_cnt, miss_cnt); end
    for (int i = 0; i < 20; i++) begin drive(1'b1, 1'b0, 4'd0, 23'h5, '0, 1'b0); tick(); end
    total++; if (hit_cnt !== 4'd15 || miss_cnt !== 4'd2) begin bad++; $display("FAIL perf_hit_sat got=%0d/%0d want=15/2", hit_cnt, miss_cnt); end
    for (int i = 0; i < 20; i++) begin drive(1'b1, 1'b0, 4'd0, 23'h6, '0, 1'b0); tick(); end
    total++; if (miss_cnt !== 4'd15) begin bad++; $display("FAIL perf_miss_sat got=%0d want=15", miss_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 23'h0, '0, 1'b0);
    @(negedge clk);
    test_reset();
    test_refill();
    test_replace();
    test_write_hit();
    test_reset_with_write();
`ifdef DCACHE_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
